// File: rtl/rbg_pkg.sv
// Shared types and helpers for the rbg arbiter family: FSM state encoding,
// default parameter values and the wrap-around round-robin search.
package rbg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    BUSY_HI = 3'd2,
    BUSY_LO = 3'd3,
    WAIT    = 3'd4,
    GNT     = 3'd5
  } rbg_state_e;

  localparam int unsigned N_REQ_DEF       = 4;
  localparam int unsigned BUSY_PULSES_DEF = 3;
  localparam int unsigned DLY_W_DEF       = 4;
  localparam int unsigned RR_MAX          = 16;

  // Returns {valid, idx}: first set bit of vec at or after ptr, wrapping modulo n.
  function automatic logic [4:0] next_rr(input logic [3:0] ptr, input logic [15:0] vec,
                                         input int unsigned n);
    logic [4:0]  res;
    int unsigned j;
    res = 5'd0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = (32'(ptr) + i) % n;
      if ((i < n) && !res[4] && vec[j[3:0]]) begin
        res = {1'b1, j[3:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rbg_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr.
module rbg_rr_pick
  import rbg_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req_vec,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(N_REQ);

  logic [15:0] vec_s;
  logic [3:0]  ptr_s;
  logic [4:0]  res_s;

  // Widen to the search helper's fixed width and split its result.
  always_comb begin
    vec_s              = 16'd0;
    vec_s[N_REQ-1:0]   = req_vec;
    ptr_s              = 4'd0;
    ptr_s[ID_W-1:0]    = ptr;
    res_s              = next_rr(ptr_s, vec_s, N_REQ);
    valid              = res_s[4];
    idx                = ID_W'(res_s[3:0]);
  end

endmodule

// File: rtl/rbg_bus_arbiter.sv
// Round-robin arbiter driving the shared req -> busy pulses -> optional gap -> gnt
// resource handshake on behalf of N_REQ requesters. All outputs are registered.
module rbg_bus_arbiter
  import rbg_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int BUSY_PULSES = BUSY_PULSES_DEF,
  parameter int DLY_W       = DLY_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vec,
  input  logic [DLY_W-1:0]         gnt_delay,
  output logic                     bus_req,
  output logic                     bus_busy,
  output logic                     bus_gnt,
  output logic [N_REQ-1:0]         gnt_vec,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     active
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int PC_W = $clog2(BUSY_PULSES + 1);

  rbg_state_e        state_r, state_s;
  logic [ID_W-1:0]   ptr_r;
  logic [PC_W-1:0]   pulse_cnt_r;
  logic [PC_W-1:0]   pulse_inc_s;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic              pick_valid_s;
  logic [ID_W-1:0]   pick_idx_s;

  rbg_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_vec (req_vec),
    .ptr     (ptr_r),
    .valid   (pick_valid_s),
    .idx     (pick_idx_s)
  );

  // Next-state decode for the handshake sequencer.
  always_comb begin
    state_s     = state_r;
    pulse_inc_s = pulse_cnt_r + PC_W'(1);
    case (state_r)
      IDLE: begin
        if (pick_valid_s) state_s = REQ;
        else              state_s = IDLE;
      end
      REQ:     state_s = BUSY_HI;
      BUSY_HI: begin
        if (pulse_inc_s == PC_W'(BUSY_PULSES)) begin
          if (dly_cnt_r == DLY_W'(0)) state_s = GNT;
          else                        state_s = WAIT;
        end else begin
          state_s = BUSY_LO;
        end
      end
      BUSY_LO: state_s = BUSY_HI;
      // WAIT is entered with dly_cnt >= 1 and lasts exactly that many cycles.
      WAIT: begin
        if (dly_cnt_r <= DLY_W'(1)) state_s = GNT;
        else                        state_s = WAIT;
      end
      GNT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, round-robin pointer, owner and the pulse/delay counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= ID_W'(0);
      owner_id    <= ID_W'(0);
      pulse_cnt_r <= PC_W'(0);
      dly_cnt_r   <= DLY_W'(0);
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) owner_id <= pick_idx_s;
        end
        REQ: begin
          dly_cnt_r   <= gnt_delay;
          pulse_cnt_r <= PC_W'(0);
        end
        BUSY_HI: pulse_cnt_r <= pulse_inc_s;
        WAIT: begin
          if (dly_cnt_r != DLY_W'(0)) dly_cnt_r <= dly_cnt_r - DLY_W'(1);
        end
        GNT: begin
          if (owner_id == ID_W'(N_REQ - 1)) ptr_r <= ID_W'(0);
          else                              ptr_r <= owner_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req  <= 1'b0;
      bus_busy <= 1'b0;
      bus_gnt  <= 1'b0;
      gnt_vec  <= N_REQ'(0);
      active   <= 1'b0;
    end else begin
      bus_req  <= (state_s == REQ);
      bus_busy <= (state_s == BUSY_HI);
      bus_gnt  <= (state_s == GNT);
      gnt_vec  <= (state_s == GNT) ? (N_REQ'(1) << owner_id) : N_REQ'(0);
      active   <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_rbg_bus_arbiter.sv
// Directed bench for rbg_bus_arbiter: expected per-cycle output records are
// queued as stimulus is applied and compared as the DUT produces them.
module tb_rbg_bus_arbiter;

  localparam int BP = 3;

  typedef struct packed {
    logic       r;
    logic       b;
    logic       g;
    logic [3:0] gv;
    logic [1:0] own;
    logic       act;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vec;
  logic [3:0] gnt_delay;
  logic       bus_req, bus_busy, bus_gnt, active;
  logic [3:0] gnt_vec;
  logic [1:0] owner_id;

  rec_t  exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  string tag         = "init";

  rbg_bus_arbiter #(.N_REQ(4), .BUSY_PULSES(BP), .DLY_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vec   (req_vec),
    .gnt_delay (gnt_delay),
    .bus_req   (bus_req),
    .bus_busy  (bus_busy),
    .bus_gnt   (bus_gnt),
    .gnt_vec   (gnt_vec),
    .owner_id  (owner_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input logic r, input logic b, input logic g,
                              input logic [3:0] gv, input logic [1:0] own, input logic act);
    rec_t x;
    x.r = r; x.b = b; x.g = g; x.gv = gv; x.own = own; x.act = act;
    return x;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0));
  endtask

  // Full transaction: req, BP busy pulses separated by one low cycle, dly gap cycles, gnt.
  task automatic push_txn(input logic [1:0] own, input int dly);
    logic [3:0] one;
    one = 4'b0001;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, own, 1'b1));
    for (int p = 1; p <= BP; p++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, own, 1'b1));
      if (p < BP) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, own, 1'b1));
    end
    for (int d = 0; d < dly; d++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, own, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, one << own, own, 1'b1));
  endtask

  // Advance n cycles; an empty queue means the block must be idle.
  task automatic run(input int n);
    rec_t e, o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) e = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
      else                   e = exp_q.pop_front();
      o = mk(bus_req, bus_busy, bus_gnt, gnt_vec, e.act ? owner_id : 2'd0, active);
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s cycle %0d: observed req/busy/gnt/gv/own/act=%b expected %b",
               tag, cyc, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_vec = 4'b0000; gnt_delay = 4'd0;
    tag = "reset"; run(2);
    rst = 1'b0; run(2);

    tag = "single"; req_vec = 4'b0001; push_txn(2'd0, 0); run(7);
    req_vec = 4'b0000; run(3);

    tag = "delay"; req_vec = 4'b0010; gnt_delay = 4'd1; push_txn(2'd1, 1); run(8);
    req_vec = 4'b0000; gnt_delay = 4'd0; run(2);

    tag = "wrap"; req_vec = 4'b0100; push_txn(2'd2, 0); run(7);
    req_vec = 4'b0101; push_idle(1); push_txn(2'd0, 0); run(8);
    push_idle(1); push_txn(2'd2, 0); run(8);
    req_vec = 4'b0000; run(3);

    tag = "reset_mid"; req_vec = 4'b1000;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1));
    run(4);
    rst = 1'b1; req_vec = 4'b1111; run(1);
    rst = 1'b0;
    tag = "round_robin"; push_txn(2'd0, 0); run(7);
    for (int k = 1; k < 4; k++) begin
      push_idle(1); push_txn(2'(k), 0); run(8);
    end
    push_idle(1); push_txn(2'd0, 0); run(8);
    req_vec = 4'b0000; run(2);

    tag = "drop"; req_vec = 4'b0100; push_txn(2'd2, 0); run(3);
    req_vec = 4'b0000; run(4);
    run(6);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL queue_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
